// File: rtl/dsp_pkg.sv
// Shared sample types and saturation limits for the 1s17 datapath.
package dsp_pkg;

    localparam int WIDTH = 18;

    typedef logic signed [WIDTH-1:0] sample_t;

    // Saturation rails for 1s17: +131071 and -131072.
    localparam sample_t SAT_POS = sample_t'(18'h1FFFF);
    localparam sample_t SAT_NEG = sample_t'(18'h20000);

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a separate occupancy counter. There is no bypass path:
// a word pushed into an empty FIFO cannot be popped in the same cycle.
module sync_fifo #(
    parameter int WIDTH      = 18,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_push,
    input  logic                          i_pop,
    input  logic [WIDTH-1:0]              i_wdata,
    output logic [WIDTH-1:0]              o_rdata,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [$clog2(FIFO_DEPTH):0]   o_count
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (AW+1)'(FIFO_DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage array; data content needs no reset.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally modulo the power-of-2 depth; count tracks occupancy.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/interp2_zero_stuff.sv
// Upstream feeder for the 15-tap halfband interpolator: buffers symbol-rate
// samples, generates sys_clk2_en / sam_clk_en, and emits a 2x zero-stuffed
// stream on x_out aligned to sys_clk2_en.
// Build option: define GAIN_COMP_EN to double sample slots (with saturation)
// to make up the 6 dB lost to zero-stuffing.
module interp2_zero_stuff
    import dsp_pkg::*;
#(
    parameter int WIDTH      = dsp_pkg::WIDTH,
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          sys_clk,
    input  logic                          reset_n,
    input  logic signed [WIDTH-1:0]       in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic signed [WIDTH-1:0]       x_out,
    output logic                          sys_clk2_en,
    output logic                          sam_clk_en,
    output logic                          underflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0]           r_div_cnt;
    logic                    r_phase;
    logic                    r_sys_clk2_en;
    logic                    r_sam_clk_en;
    logic signed [WIDTH-1:0] r_x_out;
    logic                    r_underflow;

    logic                    w_wrap;
    logic                    w_sample_slot;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_full;
    logic                    w_empty;
    logic [WIDTH-1:0]        w_head;
    logic signed [WIDTH-1:0] w_sample;

    // Strobes and x_out all update on the edge where the divider wraps.
    assign w_wrap        = (r_div_cnt == CW'(CLK_DIV - 1));
    assign w_sample_slot = w_wrap && !r_phase;
    assign w_push        = in_valid && in_ready;
    assign w_pop         = w_sample_slot && !w_empty;

    assign in_ready    = !w_full;
    assign x_out       = r_x_out;
    assign sys_clk2_en = r_sys_clk2_en;
    assign sam_clk_en  = r_sam_clk_en;
    assign underflow   = r_underflow;

    sync_fifo #(
        .WIDTH      (WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (sys_clk),
        .i_rst_n (reset_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (in_data),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_level)
    );

    // Sample-slot value: head of FIFO, optionally doubled with saturation.
    always_comb begin
`ifdef GAIN_COMP_EN
        if (w_head[WIDTH-1] != w_head[WIDTH-2]) begin
            w_sample = w_head[WIDTH-1] ? SAT_NEG : SAT_POS;
        end else begin
            w_sample = {w_head[WIDTH-2:0], 1'b0};
        end
`else
        w_sample = w_head;
`endif
    end

    // Divider, phase toggle and registered strobes.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div_cnt     <= '0;
            r_phase       <= 1'b0;
            r_sys_clk2_en <= 1'b0;
            r_sam_clk_en  <= 1'b0;
        end else begin
            r_div_cnt     <= w_wrap ? '0 : r_div_cnt + CW'(1);
            r_phase       <= r_phase ^ w_wrap;
            r_sys_clk2_en <= w_wrap;
            r_sam_clk_en  <= w_sample_slot;
        end
    end

    // Zero-stuff mux: sample slot pops (or flags underflow), zero slot drives 0.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x_out     <= '0;
            r_underflow <= 1'b0;
        end else if (w_wrap) begin
            if (!r_phase) begin
                if (!w_empty) begin
                    r_x_out <= w_sample;
                end else begin
                    r_x_out     <= '0;
                    r_underflow <= 1'b1;
                end
            end else begin
                r_x_out <= '0;
            end
        end
    end

endmodule

// File: tb/tb_interp2_zero_stuff.sv
// Scoreboard bench for interp2_zero_stuff (CLK_DIV=4, FIFO_DEPTH=4).
// Expected x_out values are queued by the stimulus; the monitor pops one per
// sys_clk2_en. Define GAIN_COMP_EN to match a gain-compensated DUT build.
module tb_interp2_zero_stuff;
    import dsp_pkg::*;

    logic        sys_clk  = 1'b0;
    logic        reset_n  = 1'b1;
    sample_t     in_data  = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    sample_t     x_out;
    logic        sys_clk2_en;
    logic        sam_clk_en;
    logic        underflow;
    logic [2:0]  fifo_level;

    int      n_tests = 0;
    int      n_fail  = 0;
    bit      mon_en  = 1'b0;
    sample_t sb[$];
    int      last_stalls;
    int      last_lvl;
    logic    last_sam;

    interp2_zero_stuff #(
        .WIDTH      (18),
        .CLK_DIV    (4),
        .FIFO_DEPTH (4)
    ) dut (
        .sys_clk     (sys_clk),
        .reset_n     (reset_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .x_out       (x_out),
        .sys_clk2_en (sys_clk2_en),
        .sam_clk_en  (sam_clk_en),
        .underflow   (underflow),
        .fifo_level  (fifo_level)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic sample_t exp_sample(input sample_t v);
`ifdef GAIN_COMP_EN
        int d;
        d = 2 * int'(v);
        if (d > 131071) return SAT_POS;
        if (d < -131072) return SAT_NEG;
        return sample_t'(d);
`else
        return v;
`endif
    endfunction

    // Monitor: one expected value per sys_clk2_en while enabled.
    always @(negedge sys_clk) begin
        if (mon_en && sys_clk2_en) begin
            if (sb.size() == 0) begin
                check("sb_underrun", 1, 0);
            end else begin
                check("x_out_slot", x_out, sb.pop_front());
            end
        end
    end

    task automatic apply_reset();
        mon_en   = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        reset_n  = 1'b0;
        #1;
        check("rst_x_out", x_out, 0);
        check("rst_strobes", {sys_clk2_en, sam_clk_en}, 0);
        check("rst_underflow", underflow, 0);
        check("rst_level", fifo_level, 0);
        check("rst_in_ready", in_ready, 1);
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        reset_n = 1'b1;
    endtask

    task automatic push_word(input sample_t v);
        last_stalls = 0;
        last_lvl    = -1;
        @(negedge sys_clk);
        in_data  = v;
        in_valid = 1'b1;
        while (!in_ready && last_stalls < 40) begin
            if (last_stalls == 0) last_lvl = int'(fifo_level);
            last_stalls++;
            @(negedge sys_clk);
        end
        last_sam = sam_clk_en;
        if (!in_ready) check("push_timeout", in_ready, 1);
        @(posedge sys_clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_sam();
        for (int i = 0; i < 20; i++) begin
            @(negedge sys_clk);
            if (sam_clk_en) break;
        end
        if (!sam_clk_en) check("wait_sam_timeout", sam_clk_en, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0) break;
            @(negedge sys_clk);
            #1;
        end
        check("sb_drained", sb.size(), 0);
    endtask

    task automatic run_stream(input sample_t v0, input sample_t v1, input sample_t v2);
        sample_t v[3];
        v[0] = v0; v[1] = v1; v[2] = v2;
        apply_reset();
        mon_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(exp_sample(v[i]));
            sb.push_back('0);
            push_word(v[i]);
            if (i < 2) wait_sam();
        end
        drain();
        check("stream_underflow", underflow, 0);
        mon_en = 1'b0;
    endtask

    initial begin
        sample_t wf[5];
        int      lv[4];
        #2;

        // Strobe timing from reset release.
        apply_reset();
        for (int k = 1; k <= 32; k++) begin
            @(posedge sys_clk);
            #1;
            check("sys_clk2_en_t", sys_clk2_en, (k % 4) == 0);
            check("sam_clk_en_t", sam_clk_en, (k % 8) == 4);
        end

        // Zero-stuffed streams (second set exercises saturation when enabled).
        run_stream(18'sd10000, -18'sd20000, 18'sd65535);
        run_stream(18'sd70000, -18'sd70000, 18'sd1000);

        // Full FIFO: 4 words fill it, the 5th stalls until the first pop.
        wf[0] = 18'sd100;  wf[1] = -18'sd200;   wf[2] = 18'sd300;
        wf[3] = -18'sd400; wf[4] = 18'sd131071;
        apply_reset();
        mon_en = 1'b1;
        sb.push_back('0);
        sb.push_back('0);
        wait_sam();
        for (int i = 0; i < 5; i++) begin
            sb.push_back(exp_sample(wf[i]));
            sb.push_back('0);
            push_word(wf[i]);
            if (i < 4) begin
                check("full_no_stall", last_stalls, 0);
            end else begin
                check("full_stall_cycles", last_stalls, 3);
                check("full_level_at_stall", last_lvl, 4);
                check("full_accept_after_pop", last_sam, 1);
            end
        end
        drain();
        mon_en = 1'b0;

        // Starvation; a push landing on an empty sample slot is stored, not bypassed.
        apply_reset();
        #1;
        check("starve_uf_initial", underflow, 0);
        mon_en = 1'b1;
        sb.push_back('0);
        sb.push_back('0);
        sb.push_back(exp_sample(18'sd1234));
        sb.push_back('0);
        repeat (2) @(negedge sys_clk);
        push_word(18'sd1234);
        check("starve_uf_set", underflow, 1);
        check("starve_level_stored", fifo_level, 1);
        drain();
        check("starve_uf_sticky", underflow, 1);
        check("starve_level_end", fifo_level, 0);
        mon_en = 1'b0;

        // Mid-stream async reset with 3 words queued.
        lv[0] = 1; lv[1] = 2; lv[2] = 2; lv[3] = 3;
        apply_reset();
        mon_en = 1'b1;
        sb.push_back(exp_sample(18'sd500));
        for (int i = 0; i < 4; i++) begin
            push_word(sample_t'(500 * (i + 1)));
            check("mid_level", fifo_level, lv[i]);
        end
        check("mid_x_out_hold", x_out, exp_sample(18'sd500));
        check("mid_sb_empty", sb.size(), 0);
        #2;
        apply_reset();
        for (int k = 1; k <= 4; k++) begin
            @(posedge sys_clk);
            #1;
            check("restart_clk2_en", sys_clk2_en, k == 4);
            check("restart_sam_en", sam_clk_en, k == 4);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/interp2_zero_stuff.md
Name: interp2_zero_stuff

Overview:
- Upstream feeder for the 15-tap halfband interpolation filter.
- Accepts 1s17 symbol-rate samples over a valid/ready handshake and buffers them in a small FIFO.
- Generates the sys_clk2_en and sam_clk_en strobes from sys_clk.
- Emits a 2x zero-stuffed sample stream, aligned to sys_clk2_en, for the filter's x_in.

Parameters:
- WIDTH, 18: sample width, 1s17 signed.
- CLK_DIV, 4: sys_clk cycles per sys_clk2_en pulse; must be >= 2.
- FIFO_DEPTH, 4: input FIFO entries; power of 2, >= 2.

Ports:
- sys_clk  in  1  single clock for all logic.
- reset_n  in  1  asynchronous, active-low reset.
- in_data  in  WIDTH  signed 1s17 input sample.
- in_valid  in  1  in_data valid.
- in_ready  out  1  FIFO can accept; equals !full, combinational from the occupancy count.
- x_out  out  WIDTH  signed 1s17 zero-stuffed sample to the filter.
- sys_clk2_en  out  1  one-sys_clk-wide strobe, every CLK_DIV cycles.
- sam_clk_en  out  1  one-sys_clk-wide strobe on every 2nd sys_clk2_en.
- underflow  out  1  sticky flag: a sample slot was reached with the FIFO empty.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset (async assert, sync release): div_cnt=0, phase=0, FIFO empty, all outputs 0 (x_out=0, strobes=0, underflow=0, fifo_level=0). in_ready=1 immediately, since FIFO is empty.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - sys_clk2_en is registered, high in the cycle after div_cnt==CLK_DIV-1. First pulse occurs CLK_DIV cycles after reset release.
- Phase:
  - phase toggles on each sys_clk2_en.
  - sam_clk_en = registered (div_cnt==CLK_DIV-1 && phase==0), so it is coincident with every other sys_clk2_en, starting with the first.
- Push: occurs when in_valid && in_ready; in_data is written at wr_ptr. Pointers wrap modulo FIFO_DEPTH. Occupancy is tracked with a separate count register.
- Output, updated on the same cycle the strobes assert. It is a registered output and holds between strobes.
  - Sample slot (sam_clk_en): if FIFO not empty, pop and x_out<=head. If FIFO empty, x_out<=0, underflow<=1, no pop.
  - Zero slot (sys_clk2_en && !sam_clk_en): x_out<=0.
- Latency: a sample pushed into an empty FIFO at least 1 cycle before a sample slot appears on x_out at that slot.
- Simultaneous push and pop:
  - count unchanged.
  - If the FIFO is full, the push is refused because in_ready=0 that cycle; no bypass.
  - If the FIFO is empty, the pop slot underflows and the pushed word is stored; no bypass.
- underflow clears only on reset.
- Reset mid-stream discards FIFO contents and restarts the divider at 0.

Optional Feature:
- GAIN_COMP_EN: compensates the 6 dB loss from zero-stuffing.
  - Defined: sample slots output the popped sample <<1 with saturation to +131071 / -131072 (0x1FFFF / 0x20000); zero slots are unchanged.
  - Undefined: the sample is passed unscaled.

Decomposition:
- Package dsp_pkg: WIDTH constant, signed sample_t typedef, SAT_POS/SAT_NEG constants.
- Sub-module sync_fifo (WIDTH, FIFO_DEPTH): push/pop, full/empty, count. No bypass.
- Strobe generation and zero-stuff muxing stay in the top module.

Test Plan:
- Strobe check: release reset, run 32 cycles with CLK_DIV=4.
  - sys_clk2_en pulses at cycles 4, 8, 12, ...
  - sam_clk_en pulses at cycles 4, 12, 20, ...
  - Both pulses are exactly 1 cycle wide.
- Stream check: push 10000, -20000, 65535, one per sam_clk_en.
  - x_out sequence at sys_clk2_en is 10000, 0, -20000, 0, 65535, 0.
  - underflow stays 0.
- Full FIFO: push 5 words back-to-back before the first sample slot.
  - in_ready drops after 4 words and the 5th is stalled.
  - It is accepted on the cycle after the first pop.
- Starvation: no input.
  - x_out stays 0 and underflow sets at the first sam_clk_en.
  - A later push of 1234 appears at the next sample slot; underflow remains 1.
- Mid-stream reset: assert reset_n low asynchronously with 3 words queued.
  - Outputs go to 0 immediately and fifo_level=0.
  - The next strobe occurs CLK_DIV cycles after release.
- GAIN_COMP_EN: inputs 70000, -70000, 1000.
  - Outputs are 131071, -131072, 2000, with zeros between.
